// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole round controller.
package mole_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int NUM_MOLES = 4;
  localparam int LFSR_W    = 8;
  // Fibonacci taps at positions 8,6,5,4 (1-based) give a maximal-length sequence.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;
  localparam int SCORE_W   = 8;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used to pick the lit mole.
module mole_lfsr
  import mole_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] value
);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) value <= seed;
    else        value <= lfsr_step(value);
  end

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: lights a mole, scores hits, counts rounds.
// Optional miss counter enabled by defining MOLE_MISS_CNT_EN.
//
// state    | meaning
// ST_IDLE  | waiting for first start edge after reset
// ST_LOAD  | timer reload, no mole lit, LOAD_CYCLES long
// ST_ARMED | mole lit, timer running, waiting for hit or miss
// ST_DONE  | game finished, counters frozen until next start
module mole_round_ctrl
  import mole_pkg::*;
#(
  parameter int                ROUNDS      = 10,
  parameter int                LOAD_CYCLES = 2,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 8'hA5
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [NUM_MOLES-1:0] btn_i,
  input  logic [3:0]           timer_count_i,
  input  logic                 timer_done_i,
  output logic                 timer_run_o,
  output logic [NUM_MOLES-1:0] mole_o,
  output logic [SCORE_W-1:0]   score_o,
  output logic [SCORE_W-1:0]   miss_o,
  output logic [7:0]           round_o,
  output logic                 game_over_o
);

  logic [1:0]           rst_sync;
  logic                 rst_n;
  state_e               state_q, state_d;
  logic                 start_q;
  logic [NUM_MOLES-1:0] btn_q, btn_rise, mole_oh;
  logic [15:0]          load_cnt_q;
  logic [1:0]           idx_q, idx_pick;
  logic [SCORE_W-1:0]   score_q;
  logic [7:0]           round_q;
  logic [LFSR_W-1:0]    lfsr;
  logic                 unused_lfsr;
  logic                 start_rise, expire, hit, miss, enter_load, clear_cnt;

  // Assert asynchronously, release two clocks later so no flop sees a runt edge.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  mole_lfsr u_lfsr (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .seed  (LFSR_SEED),
    .value (lfsr)
  );
  assign unused_lfsr = ^lfsr[LFSR_W-1:2];

  assign start_rise = start_i & ~start_q;
  assign btn_rise   = btn_i & ~btn_q;
  assign mole_oh    = NUM_MOLES'(1) << idx_q;
  assign expire     = timer_done_i && (timer_count_i == 4'd0);
  assign idx_pick   = (lfsr[1:0] == idx_q) ? lfsr[1:0] + 2'd1 : lfsr[1:0];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    hit        = 1'b0;
    miss       = 1'b0;
    enter_load = 1'b0;
    clear_cnt  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_rise) begin
          state_d    = ST_LOAD;
          enter_load = 1'b1;
          clear_cnt  = 1'b1;
        end
      end
      ST_LOAD: begin
        if (load_cnt_q == 16'd0) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        // mole_oh is one-hot, so equality also enforces a single rising button.
        if (btn_rise == mole_oh)                     hit  = 1'b1;
        else if ((btn_rise != '0) || expire)         miss = 1'b1;
        if (hit || miss) begin
          if (round_q == 8'(ROUNDS - 1)) state_d = ST_DONE;
          else begin
            state_d    = ST_LOAD;
            enter_load = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      start_q    <= 1'b1;
      btn_q      <= '1;
      load_cnt_q <= 16'd0;
      idx_q      <= 2'd0;
      score_q    <= '0;
      round_q    <= 8'd0;
    end else begin
      start_q <= start_i;
      btn_q   <= btn_i;
      if (enter_load) begin
        load_cnt_q <= 16'(LOAD_CYCLES - 1);
        idx_q      <= idx_pick;
      end else if ((state_q == ST_LOAD) && (load_cnt_q != 16'd0)) begin
        load_cnt_q <= load_cnt_q - 16'd1;
      end
      if (clear_cnt) begin
        score_q <= '0;
        round_q <= 8'd0;
      end else begin
        if (hit && (score_q != '1)) score_q <= score_q + 1'b1;
        if (hit || miss)            round_q <= round_q + 8'd1;
      end
    end
  end

`ifdef MOLE_MISS_CNT_EN
  logic [SCORE_W-1:0] miss_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)                         miss_q <= '0;
    else if (clear_cnt)                 miss_q <= '0;
    else if (miss && (miss_q != '1))    miss_q <= miss_q + 1'b1;
  end
  assign miss_o = miss_q;
`else
  assign miss_o = '0;
`endif

  assign timer_run_o = (state_q == ST_ARMED);
  assign mole_o      = (state_q == ST_ARMED) ? mole_oh : '0;
  assign game_over_o = (state_q == ST_DONE);
  assign score_o     = score_q;
  assign round_o     = round_q;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Randomized directed bench for mole_round_ctrl against a counting reference model.
module tb_mole_round_ctrl;

  localparam int ROUNDS      = 10;
  localparam int LOAD_CYCLES = 2;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       start_i = 1'b0;
  logic [3:0] btn_i = 4'h0;
  logic [3:0] timer_count_i = 4'd5;
  logic       timer_done_i = 1'b0;
  logic       timer_run_o;
  logic [3:0] mole_o;
  logic [7:0] score_o, miss_o, round_o;
  logic       game_over_o;

  mole_round_ctrl #(
    .ROUNDS      (ROUNDS),
    .LOAD_CYCLES (LOAD_CYCLES),
    .LFSR_SEED   (8'hA5)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .start_i       (start_i),
    .btn_i         (btn_i),
    .timer_count_i (timer_count_i),
    .timer_done_i  (timer_done_i),
    .timer_run_o   (timer_run_o),
    .mole_o        (mole_o),
    .score_o       (score_o),
    .miss_o        (miss_o),
    .round_o       (round_o),
    .game_over_o   (game_over_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int exp_score = 0, exp_miss = 0, exp_round = 0;
  int prev_idx = -1, cur_idx = 0;
  logic [3:0] seen = 4'h0;
  logic game_done;

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int idx_of(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic check_counters(input string tag);
    int em;
`ifdef MOLE_MISS_CNT_EN
    em = exp_miss;
`else
    em = 0;
`endif
    chk({tag, "_score"}, int'(score_o), exp_score);
    chk({tag, "_miss"},  int'(miss_o),  em);
    chk({tag, "_round"}, int'(round_o), exp_round);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_run"},   int'(timer_run_o), 0);
    chk({tag, "_mole"},  int'(mole_o), 0);
    chk({tag, "_score"}, int'(score_o), 0);
    chk({tag, "_miss"},  int'(miss_o), 0);
    chk({tag, "_round"}, int'(round_o), 0);
    chk({tag, "_over"},  int'(game_over_o), 0);
  endtask

  // Called at a negedge in the timer-reload phase; returns at the first lit negedge.
  task automatic wait_armed();
    int n = 0;
    while (timer_run_o !== 1'b1 && n < 20) begin
      chk("load_mole_zero", int'(mole_o), 0);
      n++;
      @(negedge clk_i);
    end
    chk("load_len", n, LOAD_CYCLES);
    chk("mole_onehot", int'($onehot(mole_o)), 1);
    cur_idx = idx_of(mole_o);
    if (prev_idx >= 0) chk("mole_no_repeat", int'(cur_idx != prev_idx), 1);
    if (cur_idx >= 0) seen[cur_idx] = 1'b1;
    prev_idx = cur_idx;
  endtask

  task automatic start_game();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    exp_score = 0; exp_miss = 0; exp_round = 0;
    check_counters("start_clear");
    chk("start_over_clr", int'(game_over_o), 0);
    wait_armed();
  endtask

  // kind: 0 hit, 1 wrong button, 2 timeout, 3 hit with timeout, 4 two buttons
  task automatic play(input int kind, input bit hold_next, output logic done);
    logic [3:0] m;
    int other;
    bit is_hit;
    m = mole_o;
    other = (cur_idx + int'($urandom_range(1, 3))) % 4;
    is_hit = (kind == 0) || (kind == 3);
    case (kind)
      0: btn_i = m;
      1: btn_i = 4'(1 << other);
      2: begin timer_done_i = 1'b1; timer_count_i = 4'd0; end
      3: begin btn_i = m; timer_done_i = 1'b1; timer_count_i = 4'd0; end
      default: btn_i = m | 4'(1 << other);
    endcase
    @(negedge clk_i);
    if (is_hit) exp_score = (exp_score < 255) ? exp_score + 1 : 255;
    else        exp_miss  = (exp_miss < 255) ? exp_miss + 1 : 255;
    exp_round++;
    done = (exp_round == ROUNDS);
    check_counters("round_end");
    chk("round_end_over", int'(game_over_o), int'(done));
    chk("round_end_run", int'(timer_run_o), 0);
    btn_i = hold_next ? 4'hF : 4'h0;
    timer_done_i = 1'b0;
    timer_count_i = 4'd5;
    if (!done) wait_armed();
    else chk("done_mole", int'(mole_o), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset_i = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(negedge clk_i);
    reset_i = 1'b1;
    repeat (4) @(negedge clk_i);
    check_all_zero("idle");

    start_game();

    // Ignored start edge, non-expired timer flag, count zero without done flag.
    start_i = 1'b1; timer_done_i = 1'b1; timer_count_i = 4'd3;
    @(negedge clk_i);
    chk("ign_start_round", int'(round_o), 0);
    chk("ign_start_run", int'(timer_run_o), 1);
    start_i = 1'b0; timer_done_i = 1'b0; timer_count_i = 4'd0;
    @(negedge clk_i);
    chk("cnt0_nodone_round", int'(round_o), 0);
    chk("cnt0_nodone_run", int'(timer_run_o), 1);
    timer_count_i = 4'd5;

    play(0, 1'b0, game_done);
    play(2, 1'b0, game_done);
    play(3, 1'b0, game_done);
    play(1, 1'b1, game_done);
    repeat (3) begin
      @(negedge clk_i);
      chk("held_btn_round", int'(round_o), exp_round);
      chk("held_btn_run", int'(timer_run_o), 1);
    end
    btn_i = 4'h0;
    @(negedge clk_i);
    play(0, 1'b0, game_done);
    while (!game_done) play(int'($urandom_range(0, 4)), 1'b0, game_done);

    chk("over_flag", int'(game_over_o), 1);
    chk("over_mole", int'(mole_o), 0);
    chk("over_run", int'(timer_run_o), 0);
    btn_i = 4'h2;
    repeat (3) @(negedge clk_i);
    btn_i = 4'h0;
    check_counters("over_hold");

    start_game();
    for (int r = 0; r < 100; r++) begin
      play(int'($urandom_range(0, 4)), 1'b0, game_done);
      if (game_done) start_game();
    end
    chk("all_idx_seen", int'(seen), 15);

    chk("pre_reset_run", int'(timer_run_o), 1);
    #2 reset_i = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk_i);
    reset_i = 1'b1;
    repeat (4) @(negedge clk_i);
    check_all_zero("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mole_round_ctrl.md
MOLE_ROUND_CTRL -- requirements
Module: mole_round_ctrl

Interface
REQ-001 The block SHALL have parameter ROUNDS, default 10, meaning number of mole rounds per game (1..255).
REQ-002 The block SHALL have parameter LOAD_CYCLES, default 2, meaning cycles timer_run_o is held low to reload the countdown timer (>=1).
REQ-003 The block SHALL have parameter LFSR_SEED, default 8'hA5, meaning nonzero LFSR reset value.
REQ-004 clk_i  input  1  system clock, rising edge; the countdown timer runs on the same clock.
REQ-005 reset_i  input  1  asynchronous, active-low reset.
REQ-006 start_i  input  1  level; a rising edge starts a game from IDLE or DONE.
REQ-007 btn_i  input  4  debounced, synchronous player buttons, level, one per mole.
REQ-008 timer_count_i  input  4  countdown value from the round timer.
REQ-009 timer_done_i  input  1  timer-expired flag from the round timer.
REQ-010 timer_run_o  output  1  low = timer reload to 5, high = timer counts down.
REQ-011 mole_o  output  4  one-hot lit mole, all-zero when no mole is up.
REQ-012 score_o  output  8  hits this game.
REQ-013 miss_o  output  8  misses this game (see Configuration).
REQ-014 round_o  output  8  rounds completed this game.
REQ-015 game_over_o  output  1  high in DONE.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, ARMED, DONE.
REQ-017 IDLE -> LOAD on a start_i rising edge; score_o, miss_o and round_o SHALL clear on that edge.
REQ-018 In LOAD, timer_run_o SHALL be 0 for exactly LOAD_CYCLES cycles, mole_o SHALL be 0, and the block SHALL then enter ARMED.
REQ-019 On LOAD entry, the mole index SHALL be lfsr[1:0]; if it equals the previous round's index, it SHALL be (index+1) mod 4.
REQ-020 In ARMED, timer_run_o SHALL be 1 and mole_o SHALL be one-hot of the index.
REQ-021 A hit SHALL be a cycle in which exactly one btn_i bit rises (0->1 versus the registered prior value) and that bit matches mole_o.
REQ-022 A miss SHALL be any other btn_i rising edge, or timer_done_i=1 with timer_count_i=0.
REQ-023 On a hit, score_o SHALL increment with saturation at 255.
REQ-024 Each hit or miss SHALL increment round_o, end the round, and go to LOAD, or to DONE when round_o reaches ROUNDS.
REQ-025 If a hit and a timer expiry occur in the same cycle, the hit SHALL win.
REQ-026 Buttons already held at ARMED entry SHALL NOT count until they are released and pressed again.
REQ-027 In DONE, game_over_o=1, mole_o=0 and timer_run_o=0; counters SHALL hold until a start_i rising edge, which clears them and goes to LOAD.
REQ-028 start_i edges outside IDLE/DONE SHALL be ignored.
REQ-029 The LFSR SHALL be 8-bit Fibonacci, taps 8,6,5,4, and advance every cycle regardless of state.

Reset
REQ-030 With reset_i=0, outputs SHALL be: state IDLE, timer_run_o=0, mole_o=0, score_o=0, miss_o=0, round_o=0, game_over_o=0, lfsr=LFSR_SEED, and button history all-ones.
REQ-031 Reset asserted mid-round SHALL take effect immediately, without waiting for a clock edge; release SHALL be synchronized so the first active edge is clean.

Configuration
REQ-032 With MOLE_MISS_CNT_EN defined, miss_o SHALL count misses with saturation at 255; without it, miss_o SHALL be constant 0 and the counter SHALL not be synthesized.

Structure
REQ-033 Package mole_pkg SHALL hold the FSM state enum, NUM_MOLES=4, the LFSR width and taps, and the score width.
REQ-034 LFSR logic SHALL be sub-module mole_lfsr (clk, async active-low reset, seed, 8-bit state output).

Verification
REQ-035 Start pulse -> timer_run_o low for 2 cycles, then high; mole_o one-hot; round_o=0.
REQ-036 Press the matching button in ARMED -> score_o=1, round_o=1, back to LOAD the next cycle.
REQ-037 No press; timer_count_i=0 and timer_done_i=1 -> miss_o=1 (macro on) or 0 (macro off), round_o=1, score_o=0.
REQ-038 Matching press in the same cycle as timer expiry -> score_o increments, miss_o unchanged.
REQ-039 Ten rounds with ROUNDS=10 -> game_over_o=1, mole_o=0; a new start clears score_o to 0.
REQ-040 reset_i low mid-ARMED -> all outputs zero before the next clk edge; consecutive moles never repeat an index across 100 rounds.
